// File: rtl/conv33_frame_sched_if.sv
// Handshake bundle between the frame scheduler (master) and its surrounding datapath (slave).
// Widths must match the scheduler's COL_W/ROW_W/CH_W.
interface conv33_frame_sched_if #(
    parameter int unsigned COL_W = 5,
    parameter int unsigned ROW_W = 5,
    parameter int unsigned CH_W  = 2
);
    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic             wgt_req;
    logic [CH_W-1:0]  wgt_ch;
    logic             wgt_ack;
    logic             win_valid;
    logic             win_ready;
    logic             conv_valid;
    logic             conv_ready;
    logic [COL_W-1:0] pos_col;
    logic [ROW_W-1:0] pos_row;
    logic [CH_W-1:0]  pos_ch;
    logic             first_ch;
    logic             last_ch;
    logic             last_win;

    modport master (
        input  start, abort, wgt_ack, win_valid, conv_ready,
        output busy, done, wgt_req, wgt_ch, win_ready, conv_valid,
        output pos_col, pos_row, pos_ch, first_ch, last_ch, last_win
    );

    modport slave (
        output start, abort, wgt_ack, win_valid, conv_ready,
        input  busy, done, wgt_req, wgt_ch, win_ready, conv_valid,
        input  pos_col, pos_row, pos_ch, first_ch, last_ch, last_win
    );
endinterface

// File: rtl/conv33_frame_sched.sv
// Frame scheduler for the 3x3 conv input path: per-channel weight load, then gated window
// handshake with position/channel tagging; done pulses after the last window of the last channel.
module conv33_frame_sched #(
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned IMG_H  = 28,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned COL_W  = $clog2(IMG_W),
    parameter int unsigned ROW_W  = $clog2(IMG_H),
    parameter int unsigned CH_W   = ($clog2(NUM_CH) > 0) ? $clog2(NUM_CH) : 1
) (
    input logic                  clk,
    input logic                  rst,
    conv33_frame_sched_if.master bus
);

    localparam logic [COL_W-1:0] ColLast = COL_W'(IMG_W - 3);
    localparam logic [ROW_W-1:0] RowLast = ROW_W'(IMG_H - 3);
    localparam logic [CH_W-1:0]  ChLast  = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {StIdle, StWload, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             wgt_req_q, wgt_req_d;

    logic run, xfer, last_win, last_ch;

    assign run      = (state_q == StRun);
    assign xfer     = bus.win_valid & bus.conv_ready & run;
    assign last_win = (col_q == ColLast) && (row_q == RowLast);
    assign last_ch  = (ch_q == ChLast);

    assign bus.conv_valid = bus.win_valid & run;
    assign bus.win_ready  = bus.conv_ready & run;
    assign bus.pos_col    = col_q;
    assign bus.pos_row    = row_q;
    assign bus.pos_ch     = ch_q;
    assign bus.first_ch   = (ch_q == '0);
    assign bus.last_ch    = last_ch;
    assign bus.last_win   = last_win;
    assign bus.wgt_ch     = ch_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.wgt_req    = wgt_req_q;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        ch_d    = ch_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StWload;
                    col_d   = '0;
                    row_d   = '0;
                    ch_d    = '0;
                end
            end
            StWload: begin
                if (bus.wgt_ack) state_d = StRun;
            end
            StRun: begin
                if (xfer) begin
                    if (col_q == ColLast) begin
                        col_d = '0;
                        row_d = (row_q == RowLast) ? '0 : row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                    if (last_win) begin
                        if (last_ch) begin
                            state_d = StDone;
                            ch_d    = '0;
                        end else begin
                            state_d = StWload;
                            ch_d    = ch_q + CH_W'(1);
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Abort wins over any xfer or wgt_ack in the same cycle.
        if (bus.abort && (state_q != StIdle)) begin
            state_d = StIdle;
            col_d   = '0;
            row_d   = '0;
            ch_d    = '0;
        end
        busy_d    = (state_d != StIdle);
        done_d    = (state_d == StDone);
        wgt_req_d = (state_d == StWload);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            col_q     <= '0;
            row_q     <= '0;
            ch_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wgt_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            ch_q      <= ch_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wgt_req_q <= wgt_req_d;
        end
    end

endmodule

// File: tb/tb_conv33_frame_sched.sv
// Bench for conv33_frame_sched: a 5x5x2 instance and a 3x3x1 instance driven with random stalls,
// checked against a window-index model (window k -> channel, row, column by plain arithmetic).
module tb_conv33_frame_sched;

    logic clk;
    logic rst_a, rst_b;
    logic sel;
    logic start, abort, ack, wv, cr;

    int n_checks;
    int n_errors;

    conv33_frame_sched_if #(.COL_W(3), .ROW_W(3), .CH_W(1)) if_a ();
    conv33_frame_sched_if #(.COL_W(2), .ROW_W(2), .CH_W(1)) if_b ();

    conv33_frame_sched #(.IMG_W(5), .IMG_H(5), .NUM_CH(2)) u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (if_a)
    );

    conv33_frame_sched #(.IMG_W(3), .IMG_H(3), .NUM_CH(1)) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (if_b)
    );

    assign if_a.start      = start & ~sel;
    assign if_a.abort      = abort;
    assign if_a.wgt_ack    = ack;
    assign if_a.win_valid  = wv;
    assign if_a.conv_ready = cr;
    assign if_b.start      = start & sel;
    assign if_b.abort      = abort;
    assign if_b.wgt_ack    = ack;
    assign if_b.win_valid  = wv;
    assign if_b.conv_ready = cr;

    int m_busy, m_done, m_req, m_wch, m_cv, m_wr, m_col, m_row, m_ch, m_fc, m_lc, m_lw;

    always_comb begin
        m_busy = sel ? int'(if_b.busy)       : int'(if_a.busy);
        m_done = sel ? int'(if_b.done)       : int'(if_a.done);
        m_req  = sel ? int'(if_b.wgt_req)    : int'(if_a.wgt_req);
        m_wch  = sel ? int'(if_b.wgt_ch)     : int'(if_a.wgt_ch);
        m_cv   = sel ? int'(if_b.conv_valid) : int'(if_a.conv_valid);
        m_wr   = sel ? int'(if_b.win_ready)  : int'(if_a.win_ready);
        m_col  = sel ? int'(if_b.pos_col)    : int'(if_a.pos_col);
        m_row  = sel ? int'(if_b.pos_row)    : int'(if_a.pos_row);
        m_ch   = sel ? int'(if_b.pos_ch)     : int'(if_a.pos_ch);
        m_fc   = sel ? int'(if_b.first_ch)   : int'(if_a.first_ch);
        m_lc   = sel ? int'(if_b.last_ch)    : int'(if_a.last_ch);
        m_lw   = sel ? int'(if_b.last_win)   : int'(if_a.last_win);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame on the selected instance. Inputs change on the falling edge; outputs are
    // sampled 1 time unit later, well before the next rising edge.
    task automatic run_frame(input int ack_dly, input bit stall, input int abort_at,
                             input int rst_at, input bit glitch, input bit chained,
                             input bit chain_next);
        int ow, nch, per_ch, total, k, p, req_len, req_pulses, cyc, last_xfer;
        bit ended, aborted, reset_hit;
        ow         = sel ? 1 : 3;
        nch        = sel ? 1 : 2;
        per_ch     = ow * ow;
        total      = per_ch * nch;
        k          = 0;
        req_len    = 0;
        req_pulses = 0;
        cyc        = 0;
        last_xfer  = -10;
        ended      = 1'b0;
        aborted    = 1'b0;
        reset_hit  = 1'b0;
        if (!chained) begin
            @(negedge clk);
            start = 1'b1;
        end
        while (!ended && cyc < 2000) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            cyc++;
            if (aborted) begin
                check("abort_busy", m_busy, 0);
                check("abort_done", m_done, 0);
                ended = 1'b1;
            end else if (m_done != 0) begin
                check("done_count", k, total);
                check("done_gap", cyc - last_xfer, 1);
                check("done_busy", m_busy, 1);
                check("req_pulses", req_pulses, nch);
                ended = 1'b1;
            end else begin
                if (m_req != 0) begin
                    req_len++;
                    if (req_len == 1) begin
                        req_pulses++;
                        check("wgt_ch", m_wch, k / per_ch);
                    end
                    ack = (req_len >= ack_dly);
                end else begin
                    if (req_len != 0) check("wgt_req_len", req_len, ack_dly);
                    req_len = 0;
                    ack = stall ? ($urandom_range(1) != 0) : 1'b0;
                end
                wv = stall ? ($urandom_range(3) != 0) : 1'b1;
                cr = stall ? ($urandom_range(3) != 0) : 1'b1;
                #1;
                if (m_req != 0) begin
                    check("wload_cv", m_cv, 0);
                    check("wload_wr", m_wr, 0);
                end
                if (rst_at >= 0 && k == rst_at && m_cv != 0) begin
                    rst_a = 1'b1;
                    #1;
                    check("rst_busy", m_busy, 0);
                    check("rst_req", m_req, 0);
                    check("rst_cv", m_cv, 0);
                    check("rst_wr", m_wr, 0);
                    reset_hit = 1'b1;
                    ended     = 1'b1;
                end else begin
                    if (m_cv != 0) begin
                        p = k % per_ch;
                        check("pos_col", m_col, p % ow);
                        check("pos_row", m_row, p / ow);
                        check("pos_ch", m_ch, k / per_ch);
                        check("first_ch", m_fc, int'((k / per_ch) == 0));
                        check("last_ch", m_lc, int'((k / per_ch) == nch - 1));
                        check("last_win", m_lw, int'(p == per_ch - 1));
                        check("run_wr", m_wr, int'(cr));
                    end
                    if (m_cv != 0 && cr) begin
                        if (k == abort_at) begin
                            abort   = 1'b1;
                            aborted = 1'b1;
                        end
                        k++;
                        last_xfer = cyc;
                    end
                    if (glitch && k == 3) start = 1'b1;
                end
            end
        end
        if (!ended) check("timeout", 0, 1);
        ack = 1'b0;
        wv  = 1'b0;
        cr  = 1'b0;
        if (reset_hit) begin
            @(negedge clk);
            rst_a = 1'b0;
            check("rst_release_busy", m_busy, 0);
        end else if (!aborted) begin
            @(negedge clk);
            start = 1'b0;
            check("done_pulse_len", m_done, 0);
            check("idle_busy", m_busy, 0);
            if (chain_next) start = 1'b1;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        sel   = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        start = 1'b1;
        abort = 1'b0;
        ack   = 1'b1;
        wv    = 1'b1;
        cr    = 1'b1;
        #12;
        check("reset_busy", m_busy, 0);
        check("reset_done", m_done, 0);
        check("reset_req", m_req, 0);
        check("reset_cv", m_cv, 0);
        check("reset_wr", m_wr, 0);
        check("reset_col", m_col, 0);
        check("reset_row", m_row, 0);
        check("reset_ch", m_ch, 0);
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        start = 1'b0;
        ack   = 1'b0;
        wv    = 1'b0;
        cr    = 1'b0;

        // 5x5x2: free-running, random stalls, long weight load, abort then restart, reset mid-run.
        run_frame(1, 1'b0, -1, -1, 1'b0, 1'b0, 1'b0);
        run_frame(2, 1'b1, -1, -1, 1'b0, 1'b0, 1'b0);
        run_frame(7, 1'b1, -1, -1, 1'b0, 1'b0, 1'b0);
        run_frame(1, 1'b1, 13, -1, 1'b0, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("post_abort_done", m_done, 0);
        end
        run_frame(1, 1'b0, -1, -1, 1'b0, 1'b0, 1'b0);
        run_frame(1, 1'b0, -1, 12, 1'b1, 1'b0, 1'b0);
        run_frame(3, 1'b1, -1, -1, 1'b0, 1'b0, 1'b0);

        // 3x3x1: back-to-back frames with the minimum idle gap.
        sel = 1'b1;
        run_frame(1, 1'b0, -1, -1, 1'b0, 1'b0, 1'b1);
        run_frame(1, 1'b0, -1, -1, 1'b0, 1'b1, 1'b0);
        run_frame(4, 1'b1, -1, -1, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv33_frame_sched.md
Name: conv33_frame_sched

Overview:
Frame-level scheduler for the 3x3 convolution input path.
- Sequences one feature map of IMG_H x IMG_W pixels over NUM_CH input channels.
- Before each channel it requests a weight load, then gates the window handshake between the sliding-window source and the conv compute stage.
- Tags every transferred window with its position, channel and accumulation flags, and pulses done after the last window of the last channel.

Parameters:
IMG_W, 28, input map width in pixels (>=3); output width OUT_W = IMG_W-2 (no padding)
IMG_H, 28, input map height in pixels (>=3); OUT_H = IMG_H-2
NUM_CH, 4, number of input channels (>=1)
COL_W, $clog2(IMG_W), width of pos_col
ROW_W, $clog2(IMG_H), width of pos_row
CH_W, $clog2(NUM_CH)>0 ? $clog2(NUM_CH) : 1, width of channel indices

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  begin a frame; sampled only in IDLE
abort  in  1  synchronous abort; return to IDLE, no done
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on frame completion
wgt_req  out  1  weight-load request for channel wgt_ch
wgt_ch  out  CH_W  channel whose weights are to load
wgt_ack  in  1  weight load complete
win_valid  in  1  window valid from sliding-window source
win_ready  out  1  ready to the sliding-window source
conv_valid  out  1  window valid to conv compute
conv_ready  in  1  ready from conv compute
pos_col  out  COL_W  output column of the current window
pos_row  out  ROW_W  output row of the current window
pos_ch  out  CH_W  channel of the current window
first_ch  out  1  pos_ch==0 (compute clears accumulator)
last_ch  out  1  pos_ch==NUM_CH-1 (compute emits result)
last_win  out  1  pos_col==OUT_W-1 and pos_row==OUT_H-1

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- Reset values: state IDLE; col, row and ch counters 0; busy=0, done=0, wgt_req=0.
- States: IDLE, WLOAD, RUN, DONE.
- IDLE:
  - start=1: zero col, row and ch; go to WLOAD.
  - start is ignored in all other states.
- WLOAD:
  - wgt_req=1 and wgt_ch=ch, held until wgt_ack.
  - wgt_ack=1: go to RUN next cycle. wgt_req drops in the same cycle the state leaves WLOAD.
  - wgt_ack outside WLOAD is ignored.
- RUN, combinational gating:
  - conv_valid = win_valid & (state==RUN)
  - win_ready = conv_ready & (state==RUN)
  - xfer = win_valid & conv_ready & (state==RUN)
  - Outside RUN, conv_valid=0 and win_ready=0, so no window is consumed.
- Counters and tags:
  - pos_col, pos_row and pos_ch are the registered counters. They tag the window offered in the current cycle and are stable while stalled.
  - first_ch, last_ch and last_win are combinational from the counters.
- On xfer:
  - col < OUT_W-1: col++.
  - Otherwise col=0, and row++ (row < OUT_H-1) or row=0.
  - If last_win: last_ch → DONE; otherwise ch++ → WLOAD.
- Transfer count: each channel transfers exactly OUT_W*OUT_H windows. There is no bubble at wrap beyond the WLOAD handshake, which is at least 1 cycle.
- DONE: done=1 for exactly one cycle, busy=1; go to IDLE. Counters return to 0.
- abort: in any non-IDLE state, next cycle is IDLE with counters 0. No done pulse and no wgt_req. abort has priority over xfer and wgt_ack in the same cycle.
- rst mid-frame: immediate IDLE with all outputs at reset values. In-flight handshakes are dropped.
- NUM_CH=1: first_ch and last_ch are both 1 throughout; one WLOAD per frame.
- Back-to-back frames: start asserted in the cycle after DONE (state IDLE) is accepted. Minimum idle gap between frames is 1 cycle.

Test Plan:
- IMG_W=IMG_H=5, NUM_CH=2, win_valid and conv_ready tied 1, wgt_ack 1 cycle after req:
  - wgt_req pulses with wgt_ch=0 then wgt_ch=1.
  - 9 xfers per channel with pos (col,row) sequence (0,0),(1,0),(2,0),(0,1)…(2,2).
  - last_win only on the 9th and 18th xfer; first_ch on xfers 1–9, last_ch on 10–18.
  - done pulses once, 1 cycle after the 18th xfer.
- Random conv_ready/win_valid stalls:
  - pos_* stay stable while conv_valid=1 and conv_ready=0.
  - Exactly 18 xfers in total; no window consumed during WLOAD (win_ready=0).
- wgt_ack delayed 7 cycles:
  - wgt_req held 7 cycles.
  - conv_valid=0 and win_ready=0 throughout WLOAD.
- abort asserted on the 5th xfer of channel 1, coincident with xfer:
  - Next cycle busy=0, done never asserted.
  - A following start restarts at ch=0, col=0, row=0.
- rst asserted asynchronously mid-RUN:
  - busy, wgt_req, conv_valid and win_ready go 0 without a clock edge.
  - start pulses during RUN are ignored (no counter reset).
- NUM_CH=1, IMG 3x3:
  - One wgt_req, one xfer with first_ch=last_ch=last_win=1, done pulse.
  - A second start 1 cycle later runs a full second frame.
